// File: rtl/mem_boot_loader.sv
// mem_boot_loader: boot-time byte-stream program loader and single-cycle word memory
module mem_boot_loader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE = 256,
  parameter int LOAD_START_ADDRESS = 212,
  parameter int LOAD_WORDS = 44,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 load_start,
  input  logic [AW-1:0]        mem_addr,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic [MEM_WIDTH-1:0] mem_write_val,
  output logic [MEM_WIDTH-1:0] mem_read_val,
  output logic                 stall,
  output logic                 load_done,
  output logic [AW:0]          load_count
);
  typedef enum logic {LOAD, RUN} state_e;
  state_e state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [AW:0] word_idx_q, word_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [MEM_WIDTH-1:0] mem [MEM_SIZE];
  logic we, in_range;
  logic [AW-1:0] waddr;
  logic [MEM_WIDTH-1:0] wdata;
  logic [31:0] load_addr;
  assign stall = state_q == LOAD;
  assign rx_ready = state_q == LOAD;
  assign load_done = state_q == RUN;
  assign load_count = word_idx_q;
  assign in_range = 32'(mem_addr) < MEM_SIZE;
  assign load_addr = (LOAD_START_ADDRESS + int'(word_idx_q)) % MEM_SIZE;
  assign mem_read_val = (state_q == RUN && mem_read_en && in_range) ? mem[mem_addr] : '0;
  // next state: byte assembly and loader writes in LOAD, datapath writes and restart in RUN
  always_comb begin
    state_d = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    shift_d = shift_q;
    we = 1'b0;
    waddr = mem_addr;
    wdata = mem_write_val;
    if (state_q == RUN) begin
      we = mem_write_en && in_range;
      if (load_start) begin
        state_d = LOAD;
        byte_idx_d = '0;
        word_idx_d = '0;
        shift_d = '0;
      end
    end else if (rx_valid) begin
      shift_d = {shift_q[15:0], rx_data};
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) begin
        we = 1'b1;
        waddr = load_addr[AW-1:0];
        wdata = {shift_q, rx_data};
        word_idx_d = word_idx_q + 1'b1;
        state_d = (word_idx_d == (AW+1)'(LOAD_WORDS)) ? RUN : LOAD;
      end
    end
  end
  // state register; reset leaves the storage array untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      shift_q <= shift_d;
    end
  end
  // storage array write port shared by loader and datapath
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: randomized check of two loaders (start 212 and wrapping start 255) against a word-level model
module tb_mem_boot_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, rx_valid, load_start, mem_read_en, mem_write_en;
  logic [7:0] rx_data, mem_addr;
  logic [31:0] mem_write_val;
  logic rx_ready [2];
  logic stall [2];
  logic load_done [2];
  logic [8:0] load_count [2];
  logic [31:0] mem_read_val [2];
  mem_boot_loader #(.LOAD_START_ADDRESS(212), .LOAD_WORDS(2)) u_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready[0]),
    .load_start(load_start), .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val[0]), .stall(stall[0]),
    .load_done(load_done[0]), .load_count(load_count[0]));
  mem_boot_loader #(.LOAD_START_ADDRESS(255), .LOAD_WORDS(2)) u_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready[1]),
    .load_start(load_start), .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val[1]), .stall(stall[1]),
    .load_done(load_done[1]), .load_count(load_count[1]));
  int starts [2] = '{212, 255};
  logic [31:0] mdl [2][256];
  bit vld [2][256];
  bit loading;
  int nbytes;
  logic [31:0] cur;
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rst, input bit rv, input logic [7:0] rx, input bit st,
                      input bit re, input bit we, input logic [7:0] a, input logic [31:0] wv);
    reset = rst; rx_valid = rv; rx_data = rx; load_start = st;
    mem_read_en = re; mem_write_en = we; mem_addr = a; mem_write_val = wv;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall%0d", k), 32'(stall[k]), 32'(loading));
      check($sformatf("rx_ready%0d", k), 32'(rx_ready[k]), 32'(loading));
      check($sformatf("load_done%0d", k), 32'(load_done[k]), 32'(!loading));
      check($sformatf("load_count%0d", k), 32'(load_count[k]), 32'(nbytes / 4));
      if (loading || !re) check($sformatf("rd_zero%0d", k), mem_read_val[k], 32'h0);
      else if (vld[k][a]) check($sformatf("rd%0d[%0d]", k, a), mem_read_val[k], mdl[k][a]);
    end
    @(posedge clk);
    if (rst) begin
      loading = 1; nbytes = 0; cur = 0;
    end else if (loading) begin
      if (rv) begin
        cur = (cur << 8) | 32'(rx);
        nbytes++;
        if (nbytes % 4 == 0)
          for (int k = 0; k < 2; k++) begin
            mdl[k][(starts[k] + nbytes / 4 - 1) % 256] = cur;
            vld[k][(starts[k] + nbytes / 4 - 1) % 256] = 1;
          end
        if (nbytes == 8) loading = 0;
      end
    end else begin
      if (we)
        for (int k = 0; k < 2; k++) begin
          mdl[k][a] = wv;
          vld[k][a] = 1;
        end
      if (st) begin
        loading = 1; nbytes = 0; cur = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic send(input bit rv, input logic [7:0] b);
    step(0, rv, b, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
  endtask
  task automatic op(input bit re, input bit we, input logic [7:0] a, input logic [31:0] wv);
    step(0, 0, 8'($urandom), 0, re, we, a, wv);
  endtask
  logic [7:0] img [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  bit gaps [7] = '{1, 0, 0, 1, 1, 0, 1};
  initial begin
    reset = 1; rx_valid = 0; rx_data = 0; load_start = 0;
    mem_read_en = 0; mem_write_en = 0; mem_addr = 0; mem_write_val = 0;
    @(posedge clk);
    @(negedge clk);
    loading = 1; nbytes = 0; cur = 0;
    foreach (img[i]) send(1, img[i]);
    op(1, 0, 213, 0);
    check("img212", mdl[0][212], 32'h12345678);
    check("img213", mdl[0][213], 32'hAABBCCDD);
    op(0, 0, 213, 0);
    op(1, 0, 212, 0);
    op(1, 0, 255, 0);
    op(1, 0, 0, 0);
    op(0, 1, 5, 32'h11111111);
    op(1, 1, 5, 32'hDEADBEEF);
    op(1, 0, 5, 0);
    step(0, 0, 0, 1, 0, 1, 7, 32'h77777777);
    foreach (gaps[i]) send(gaps[i], 8'($urandom));
    repeat (4) send(1, 8'($urandom));
    op(1, 0, 7, 0);
    op(1, 0, 212, 0);
    op(1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    repeat (6) send(1, 8'($urandom));
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) send(1, 8'($urandom));
    op(1, 0, 212, 0);
    op(1, 0, 255, 0);
    repeat (30) begin
      repeat ($urandom_range(2, 12)) begin
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 1) ? 8'd212 : 8'd0);
        op(1'($urandom), 1'($urandom), a, $urandom);
      end
      step(0, 0, 0, 1, 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
      for (int i = 0; i < 200 && loading; i++) begin
        if ($urandom_range(0, 29) == 0) step(1, 1'($urandom), 8'($urandom), 0, 0, 0, 0, 0);
        else send(1'($urandom), 8'($urandom));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
Unified 32-bit word memory that sits directly downstream of the datapath's shared memory port (mem_addr/mem_read_en/mem_write_en/mem_read_val/mem_write_val). After reset it fills a program image from a byte stream while holding the datapath stalled. It then serves datapath reads and writes.
It owns the storage array, the load state machine and the stall signal fed back to the datapath.

Parameters:
MEM_WIDTH, 32, word width in bits; must be 32 (4 bytes per word)
MEM_SIZE, 256, number of words; address width AW = $clog2(MEM_SIZE)
LOAD_START_ADDRESS, 212, first word address written by the loader
LOAD_WORDS, 44, number of words loaded per load session (1..MEM_SIZE)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock; resets the FSM and counters only
rx_data  input  8  program byte from the loader source
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  block accepts a byte this cycle; a byte transfers when rx_valid && rx_ready
load_start  input  1  single-cycle pulse in RUN that starts a new load session
mem_addr  input  AW  datapath word address
mem_read_en  input  1  datapath read enable
mem_write_en  input  1  datapath write enable
mem_write_val  input  MEM_WIDTH  datapath write data
mem_read_val  output  MEM_WIDTH  read data to datapath
stall  output  1  freezes the datapath PC while high
load_done  output  1  high in RUN
load_count  output  AW+1  words written in the current or last load session

Behaviour:
- Registered state; FSM states are LOAD and RUN. Reset forces LOAD with byte_idx=0, word_idx=0, load_count=0 and shift register = 0. Storage array contents are NOT cleared by reset.
- Outputs are decoded from registered state: stall = 1 and rx_ready = 1 and load_done = 0 in LOAD; stall = 0, rx_ready = 0 and load_done = 1 in RUN.
- LOAD, byte assembly: bytes arrive MSB first. On each transfer the shift register takes {shift[23:0], rx_data}, and byte_idx increments modulo 4.
- LOAD, word write: on the transfer with byte_idx==3, the array writes {shift[23:0], rx_data} to (LOAD_START_ADDRESS + word_idx) mod MEM_SIZE on the same edge. word_idx and load_count then increment.
- LOAD exit: when that write makes word_idx == LOAD_WORDS, the next state is RUN. stall falls in the first cycle after the final byte edge, and the final word is already readable in that cycle.
- Idle cycles: a cycle with rx_valid=0 changes nothing. Bytes may arrive back-to-back at 1 byte/clk.
- In LOAD all datapath ports are ignored: no array write, and mem_read_val = 0.
- RUN, reads: combinational (zero latency, matching the single-cycle datapath). mem_read_val = mem_read_en ? array[mem_addr] : 0.
- RUN, writes: when mem_write_en=1, array[mem_addr] <= mem_write_val on the rising edge. A read of the same address in the same cycle returns the old value.
- mem_read_en and mem_write_en both high in RUN: the read returns the old data and the write takes effect at the edge.
- load_start in RUN: next state is LOAD. byte_idx, word_idx, load_count and shift clear, and stall rises the following cycle. A datapath write in that same cycle still completes. load_start in LOAD is ignored.
- reset in the middle of a load: the partially assembled word is discarded and already written words are retained. Loading restarts at LOAD_START_ADDRESS.
- Reset has priority over load_start and over byte transfers.
- Address wrap: a load that runs past MEM_SIZE-1 continues at word 0. Example: start 255 with 2 words writes 255 and then 0.
- Out-of-range mem_addr cannot occur (AW bits exactly index MEM_SIZE when it is a power of two). For a non-power-of-two MEM_SIZE, reads above MEM_SIZE-1 return 0 and writes there are dropped.

Test Plan:
1. LOAD_WORDS=2, start 212. After reset send bytes 12 34 56 78 AA BB CC DD -> array[212]=0x12345678 and array[213]=0xAABBCCDD. stall=1 through the 8th byte edge, 0 the cycle after; load_done=1, load_count=2.
2. In RUN, mem_read_en=1, mem_addr=213 -> mem_read_val=0xAABBCCDD in the same cycle. mem_read_en=0 -> mem_read_val=0.
3. RUN: write 0xDEADBEEF to addr 5 while reading addr 5 -> the read shows the old value that cycle and 0xDEADBEEF the next cycle.
4. Gaps: rx_valid toggles 1,0,0,1,1,0,1 during one word -> the word is assembled correctly, and no write occurs before the 4th accepted byte.
5. Reset after 6 of 8 bytes, then send 8 new bytes -> array[212] holds the new first word and the old partial word is discarded. stall stays 1 until the new 8th byte.
6. load_start pulse in RUN with a simultaneous write to addr 7 -> the write lands, stall=1 the next cycle, rx_ready=1, and load_count=0. start=255 with LOAD_WORDS=2 -> words land at 255 and 0.
